// File: rtl/bru_issue_arbiter.sv
// Two-requester round-robin arbiter feeding a small FIFO in front of the BRU.
// Branch and jump/mret issue queues compete; the winner is buffered in grant order.
module bru_issue_arbiter #(
  parameter int PAYLOAD_WIDTH = 256,
  parameter int DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [PAYLOAD_WIDTH-1:0]   req0_data,
  output logic                       req0_pop,
  input  logic                       req1_valid,
  input  logic [PAYLOAD_WIDTH-1:0]   req1_data,
  output logic                       req1_pop,
  output logic [PAYLOAD_WIDTH-1:0]   arb_out_data,
  output logic                       arb_out_valid,
  input  logic                       arb_out_pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     arb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic                     rr;

  logic                     pop_ok;
  logic                     can_accept;
  logic                     both;
  logic                     grant0;
  logic                     grant1;
  logic                     grant;
  logic [PAYLOAD_WIDTH-1:0] win_data;

  assign pop_ok     = arb_out_pop && (count != '0);
  assign can_accept = (count < CW'(DEPTH)) || pop_ok;
  assign both       = req0_valid && req1_valid;

  // Grant is suppressed by reset and flush so nothing is dequeued upstream.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept && !flush && !rst) begin
      unique case (1'b1)
        both: begin
          grant0 = !rr;
          grant1 = rr;
        end
        (req0_valid && !req1_valid): grant0 = 1'b1;
        (req1_valid && !req0_valid): grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign grant    = grant0 || grant1;
  assign win_data = grant1 ? req1_data : req0_data;

  assign req0_pop      = grant0;
  assign req1_pop      = grant1;
  assign arb_out_valid = (count != '0);
  assign arb_out_data  = mem[rd_ptr];
  assign arb_count     = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr     <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr     <= grant0;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(grant) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem[wr_ptr] <= win_data;
    end
  end

endmodule

// File: tb/tb_bru_issue_arbiter.sv
// Randomised and directed bench for bru_issue_arbiter.
// A queue-based model predicts grants, occupancy and head payload every cycle.
module tb_bru_issue_arbiter;

  localparam int PW    = 256;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid;
  logic [PW-1:0] req0_data;
  logic          req0_pop;
  logic          req1_valid;
  logic [PW-1:0] req1_data;
  logic          req1_pop;
  logic [PW-1:0] arb_out_data;
  logic          arb_out_valid;
  logic          arb_out_pop;
  logic          flush;
  logic [CW-1:0] arb_count;

  always #5 clk = ~clk;

  bru_issue_arbiter #(
    .PAYLOAD_WIDTH(PW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_pop(req0_pop),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_pop(req1_pop),
    .arb_out_data(arb_out_data),
    .arb_out_valid(arb_out_valid),
    .arb_out_pop(arb_out_pop),
    .flush(flush),
    .arb_count(arb_count)
  );

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] q[$];
  int            rr_m = 0;
  bit            known = 0;
  logic [PW-1:0] out_log[$];

  logic          saw0;
  logic          saw1;
  logic [CW-1:0] obs_count;
  logic          obs_valid;

  task automatic chk(input string name, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pay(input int tag, input int i);
    return {8'(tag), 216'd0, 32'(i)};
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    logic [PW-1:0] v;
    for (int k = 0; k < PW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step(input logic r, input logic f, input logic v0,
                      input logic v1, input logic p,
                      input logic [PW-1:0] d0, input logic [PW-1:0] d1);
    int   sz;
    logic can;
    logic e0;
    logic e1;
    @(negedge clk);
    rst = r;
    flush = f;
    req0_valid = v0;
    req1_valid = v1;
    req0_data = d0;
    req1_data = d1;
    arb_out_pop = p;
    #1;
    sz = q.size();
    e0 = 1'b0;
    e1 = 1'b0;
    if (known) begin
      can = (sz < DEPTH) || (p && sz > 0);
      if (!r && !f && can) begin
        if (v0 && v1) begin
          if (rr_m == 0) e0 = 1'b1;
          else e1 = 1'b1;
        end else if (v0) e0 = 1'b1;
        else if (v1) e1 = 1'b1;
      end
      chk("count", PW'(arb_count), PW'(sz));
      chk("valid", PW'(arb_out_valid), PW'(sz != 0));
      if (sz > 0) chk("head_data", arb_out_data, q[0]);
    end
    if (known || r) begin
      chk("req0_pop", PW'(req0_pop), PW'(e0));
      chk("req1_pop", PW'(req1_pop), PW'(e1));
    end
    saw0 = req0_pop;
    saw1 = req1_pop;
    obs_count = arb_count;
    obs_valid = arb_out_valid;
    if (p && arb_out_valid) out_log.push_back(arb_out_data);
    @(posedge clk);
    if (r) begin
      q.delete();
      rr_m = 0;
      known = 1;
    end else if (known) begin
      if (f) begin
        q.delete();
      end else begin
        if (p && sz > 0) void'(q.pop_front());
        if (e0) begin
          q.push_back(d0);
          rr_m = 1;
        end else if (e1) begin
          q.push_back(d1);
          rr_m = 0;
        end
      end
    end
  endtask

  initial begin
    int ia;
    int ib;
    logic [PW-1:0] z;
    z = '0;
    rst = 1'b1;
    flush = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    arb_out_pop = 1'b0;

    // reset then idle
    step(1, 0, 0, 0, 0, z, z);
    step(1, 0, 0, 0, 0, z, z);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, z, z);
    chk("idle_count", PW'(obs_count), PW'(0));
    chk("idle_valid", PW'(obs_valid), PW'(0));

    // both valid, pop every cycle: alternating order
    out_log.delete();
    ia = 0;
    ib = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 1, pay(8'hA0, ia), pay(8'hB0, ib));
      chk("one_grant", PW'(saw0 + saw1), PW'(1));
      if (saw0) ia++;
      if (saw1) ib++;
    end
    chk("rr_count", PW'(obs_count), PW'(1));
    chk("rr_ord0", out_log[0], pay(8'hA0, 0));
    chk("rr_ord1", out_log[1], pay(8'hB0, 0));
    chk("rr_ord2", out_log[2], pay(8'hA0, 1));
    chk("rr_ord3", out_log[3], pay(8'hB0, 1));

    // fill with requester 0 only, then pop while full
    step(1, 0, 0, 0, 0, z, z);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, pay(8'hC0, i), z);
    chk("fill_count", PW'(obs_count), PW'(2));
    chk("fill_nopop", PW'(saw0), PW'(0));
    step(0, 0, 1, 0, 1, pay(8'hC0, 2), z);
    chk("full_pop_grant", PW'(saw0), PW'(1));
    step(0, 0, 1, 0, 0, pay(8'hC0, 3), z);
    chk("full_pop_count", PW'(obs_count), PW'(2));

    // flush while full; rr still favours requester 1
    step(0, 1, 0, 1, 1, z, pay(8'hE0, 0));
    chk("flush_nogrant", PW'(saw1), PW'(0));
    step(0, 0, 1, 1, 0, pay(8'hE1, 0), pay(8'hE0, 1));
    chk("flush_count", PW'(obs_count), PW'(0));
    chk("flush_valid", PW'(obs_valid), PW'(0));
    chk("flush_rr", PW'(saw1), PW'(1));

    // pointer wrap with single-entry pairs
    step(1, 0, 0, 0, 0, z, z);
    out_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, pay(8'hD0, i), z);
      chk("wrap_cnt_a", PW'(obs_count), PW'(0));
      step(0, 0, 0, 0, 1, z, z);
      chk("wrap_cnt_b", PW'(obs_count), PW'(1));
    end
    for (int i = 0; i < 5; i++) chk("wrap_order", out_log[i], pay(8'hD0, i));

    // reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, pay(8'hF0, i), pay(8'hF1, i));
    chk("mid_full", PW'(obs_count), PW'(2));
    step(1, 0, 1, 1, 0, pay(8'hF0, 9), pay(8'hF1, 9));
    chk("mid_rst_pop", PW'(saw0 | saw1), PW'(0));
    step(0, 0, 1, 1, 0, pay(8'hF0, 10), pay(8'hF1, 10));
    chk("mid_count", PW'(obs_count), PW'(0));
    chk("mid_first", PW'(saw0), PW'(1));

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 150) == 0, ($urandom % 40) == 0,
           ($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 6,
           rnd_pay(), rnd_pay());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bru_issue_arbiter.md
BRU_ISSUE_ARBITER -- requirements
Module: bru_issue_arbiter

Interface
REQ-001 Parameter PAYLOAD_WIDTH, default 256, sets the width of the issue payload (packed issue_execute_pack_t) carried unmodified.
REQ-002 Parameter DEPTH, default 2, sets the number of output buffer entries; it is a power of 2 and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 (branch issue queue) has a payload.
REQ-006 req0_data  input  PAYLOAD_WIDTH  requester 0 payload.
REQ-007 req0_pop  output  1  requester 0 payload accepted this cycle.
REQ-008 req1_valid, req1_data, req1_pop  same directions and widths as requester 0, for requester 1 (jump/mret issue queue).
REQ-009 arb_out_data  output  PAYLOAD_WIDTH  head entry presented to the BRU.
REQ-010 arb_out_valid  output  1  head entry valid; drives issue_bru_fifo_data_out_valid.
REQ-011 arb_out_pop  input  1  BRU consumes the head entry this cycle; ignored when arb_out_valid=0.
REQ-012 flush  input  1  commit_feedback_pack.enable && commit_feedback_pack.flush.
REQ-013 arb_count  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-014 Occupancy is held in a count register with read and write pointers of width $clog2(DEPTH); both pointers wrap from DEPTH-1 to 0.
REQ-015 can_accept = (arb_count < DEPTH) or (arb_out_pop and arb_out_valid); this allows a write and a read in the same cycle when the buffer is full.
REQ-016 A round-robin priority register rr selects the requester that wins when both are valid; rr=0 favours requester 0.
REQ-017 Grant is combinational: when can_accept=1 and flush=0, at most one of req0_pop/req1_pop is asserted. That requester is the only valid one, or the rr-favoured one when both are valid.
REQ-018 When a grant occurs, the granted payload is written at the write pointer on the next clock edge. rr then becomes the index of the non-granted requester. rr is unchanged when no grant occurs.
REQ-019 Latency: a payload granted in cycle N appears on arb_out_data with arb_out_valid=1 no earlier than cycle N+1.
REQ-020 arb_out_valid = (arb_count != 0); arb_out_data = the entry at the read pointer and is stable while not popped.
REQ-021 A pop advances the read pointer. Each cycle, count changes by +1 for a grant only, -1 for a pop only, and 0 for both or neither.
REQ-022 Entries leave the buffer in grant order (FIFO); payloads are never reordered or modified.
REQ-023 Flush has priority over all other events: count and both pointers clear to 0 on the next edge, and req0_pop=req1_pop=0 that cycle.
REQ-024 A pop coinciding with flush is ignored: the buffer empties either way. rr is unchanged by flush.
REQ-025 No requester waits more than one grant while the other is continuously valid: starvation bound = 1 grant.
REQ-026 Overflow and underflow never occur: no write when can_accept=0, and no pointer movement on a pop when count=0.

Reset
REQ-027 While rst=1 on a clock edge: count=0, read/write pointers=0, rr=0; buffer contents are don't-care.
REQ-028 Outputs after reset: arb_out_valid=0, arb_count=0. req0_pop/req1_pop are 0 during any cycle with rst=1.
REQ-029 Reset has priority over flush, grant and pop; reset mid-operation discards all buffered entries.

Verification
REQ-030 Reset then idle: rst 1 for 2 cycles, no requests -> arb_out_valid=0, arb_count=0, pops 0 every cycle.
REQ-031 Both requesters valid continuously, arb_out_pop=1 every cycle, payloads A0,A1,... and B0,B1,... -> output order A0,B0,A1,B1,...; one grant per cycle; arb_count settles at 1.
REQ-032 Fill: only req0 valid, arb_out_pop=0 with DEPTH=2 -> grants in 2 cycles, arb_count=2, req0_pop=0 thereafter. Then set arb_out_pop=1 -> req0_pop=1 in the same cycle and arb_count stays 2.
REQ-033 Flush while arb_count=2, req1_valid=1 and arb_out_pop=1 -> no pop to req1 that cycle; next cycle arb_count=0 and arb_out_valid=0; rr value preserved.
REQ-034 Wrap-around: 5 sequential single-entry grant/pop pairs with DEPTH=2 -> payloads emerge in order across pointer wrap, count never exceeds 1.
REQ-035 Reset mid-operation with arb_count=2 and both requesters valid -> next cycle arb_count=0 and rr=0. First grant after reset goes to requester 0.
